// File: rtl/ps2_scancode_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0/E1 prefixes into key events and queues them.
// Optional macro PS2_STATUS_FILTER_EN drops keyboard status bytes in IDLE and reports them on STATUS_SEEN.
module ps2_scancode_ctrl #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic [7:0] RX_DATA,
    input  logic       RX_DONE,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic       EV_VALID,
    input  logic       EV_READY,
    output logic       OVERFLOW,
    input  logic       OVF_CLR
`ifdef PS2_STATUS_FILTER_EN
    ,
    output logic [2:0] STATUS_SEEN
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         skip, skip_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic               push;
    ev_t                push_ev;
    logic               is_status;

    ev_t                mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0]   count, cnt_after_pop, cnt_nxt;
    logic               pop, full, push_ok, ovf_set;

    // Parser next-state: prefixes steer the state, the final byte produces the event
    always_comb begin
        state_nxt    = state;
        skip_nxt     = skip;
        tmo_nxt      = tmo_cnt;
        push         = 1'b0;
        push_ev.ext  = 1'b0;
        push_ev.brk  = 1'b0;
        push_ev.code = RX_DATA;
        is_status    = 1'b0;
`ifdef PS2_STATUS_FILTER_EN
        is_status = (state == S_IDLE) &&
                    (RX_DATA inside {8'hAA, 8'hFC, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF});
`endif
        if (RX_DONE) begin
            tmo_nxt = '0;
            if (state != S_PAUSE && RX_DATA == 8'hE1) begin
                state_nxt = S_PAUSE;
                skip_nxt  = 3'd7;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (RX_DATA == 8'hE0)      state_nxt = S_EXT;
                        else if (RX_DATA == 8'hF0) state_nxt = S_BRK;
                        else                       push = !is_status;
                    end
                    S_EXT: begin
                        if (RX_DATA == 8'hF0) state_nxt = S_EXT_BRK;
                        else if (RX_DATA != 8'hE0) begin
                            push        = 1'b1;
                            push_ev.ext = 1'b1;
                            state_nxt   = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (RX_DATA == 8'hE0) state_nxt = S_EXT_BRK;
                        else if (RX_DATA != 8'hF0) begin
                            push        = 1'b1;
                            push_ev.brk = 1'b1;
                            state_nxt   = S_IDLE;
                        end
                    end
                    S_EXT_BRK: begin
                        if (RX_DATA != 8'hE0 && RX_DATA != 8'hF0) begin
                            push        = 1'b1;
                            push_ev.ext = 1'b1;
                            push_ev.brk = 1'b1;
                            state_nxt   = S_IDLE;
                        end
                    end
                    S_PAUSE: begin
                        if (skip == 3'd1) begin
                            push         = 1'b1;
                            push_ev.ext  = 1'b1;
                            push_ev.code = 8'h77;
                            state_nxt    = S_IDLE;
                        end else begin
                            skip_nxt = skip - 3'd1;
                        end
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end else if (state != S_IDLE) begin
            if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                state_nxt = S_IDLE;
                tmo_nxt   = '0;
            end else begin
                tmo_nxt = TMO_W'(tmo_cnt + 1'b1);
            end
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves that cycle
    always_comb begin
        pop           = clk_en & EV_VALID & EV_READY;
        full          = (count == CNT_W'(DEPTH));
        push_ok       = clk_en & push & (~full | pop);
        ovf_set       = clk_en & push & full & ~pop;
        rd_nxt        = pop ? PTR_W'(rd_ptr + 1'b1) : rd_ptr;
        cnt_after_pop = pop ? CNT_W'(count - 1'b1) : count;
        cnt_nxt       = CNT_W'(cnt_after_pop + CNT_W'(push_ok));
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_ev;
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state    <= S_IDLE;
            skip     <= '0;
            tmo_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            EV_VALID <= 1'b0;
            EV_CODE  <= '0;
            EV_EXT   <= 1'b0;
            EV_BREAK <= 1'b0;
            OVERFLOW <= 1'b0;
        end else if (clk_en) begin
            state    <= state_nxt;
            skip     <= skip_nxt;
            tmo_cnt  <= tmo_nxt;
            if (push_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            rd_ptr   <= rd_nxt;
            count    <= cnt_nxt;
            EV_VALID <= (cnt_nxt != '0);
            // Show-ahead head: next stored entry, or the incoming event when it lands in an empty FIFO
            if (cnt_after_pop != '0) begin
                {EV_EXT, EV_BREAK, EV_CODE} <= mem[rd_nxt];
            end else if (push_ok) begin
                {EV_EXT, EV_BREAK, EV_CODE} <= push_ev;
            end
            OVERFLOW <= ovf_set | (OVERFLOW & ~OVF_CLR);
        end
    end

`ifdef PS2_STATUS_FILTER_EN
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            STATUS_SEEN <= '0;
        end else if (clk_en) begin
            STATUS_SEEN[0] <= RX_DONE & is_status & (RX_DATA == 8'hAA);
            STATUS_SEEN[1] <= (RX_DONE & is_status & (RX_DATA inside {8'hFC, 8'h00, 8'hFF})) |
                              (STATUS_SEEN[1] & ~OVF_CLR);
            STATUS_SEEN[2] <= RX_DONE & is_status & (RX_DATA inside {8'hFA, 8'hFE, 8'hEE});
        end
    end
`endif

endmodule

// File: doc/ps2_scancode_ctrl.md
Name: ps2_scancode_ctrl

Overview:
- Sequences the byte stream from the PS/2 receiver into whole key events: handles E0 (extended), F0 (break) and E1 (Pause) prefixes.
- Queues decoded events in a small FIFO for the BBC keyboard-matrix logic.
- Sits between the PS/2 receiver (DATA/DONE) and the matrix scanner; all state advances on clk_en.

Parameters:
- DEPTH, 8, event FIFO depth in entries; power of two, 2..32.
- TIMEOUT, 1023, clk_en cycles allowed between bytes of one multi-byte sequence before the parser aborts.

Ports:
- clk  in  1  system clock.
- nRESET  in  1  reset; synchronous, active-low.
- clk_en  in  1  clock enable; all registers update only when high.
- RX_DATA  in  8  received byte; valid while RX_DONE is high.
- RX_DONE  in  1  one-clk_en-cycle pulse, byte available.
- EV_CODE  out  8  head-of-FIFO scan code.
- EV_EXT  out  1  head event was E0-prefixed (or is Pause).
- EV_BREAK  out  1  head event is a key release.
- EV_VALID  out  1  FIFO not empty.
- EV_READY  in  1  consumer accepts head; pop when EV_VALID & EV_READY & clk_en.
- OVERFLOW  out  1  sticky; an event was dropped because the FIFO was full.
- OVF_CLR  in  1  clears OVERFLOW on a clk_en cycle.

Behaviour:
- Reset: state IDLE, FIFO empty, EV_VALID=0, EV_CODE=0, EV_EXT=0, EV_BREAK=0, OVERFLOW=0, timeout counter 0.
- Parser FSM. States: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions happen only on clk_en & RX_DONE unless stated.
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE (skip count 7); any other byte -> push {ext=0,brk=0,code}.
  - EXT: E0->EXT; F0->EXT_BRK; E1->PAUSE; other byte -> push {1,0,code}, then IDLE.
  - BRK: F0->BRK; E0->EXT_BRK; E1->PAUSE; other byte -> push {0,1,code}, then IDLE.
  - EXT_BRK: E0/F0 -> stay; E1->PAUSE; other byte -> push {1,1,code}, then IDLE.
  - PAUSE: each byte decrements the skip count, contents ignored. On the 7th byte, push {1,0,8'h77} and go to IDLE. Pause has no break event.
- Timeout:
  - The counter runs on clk_en while state != IDLE and clears on every RX_DONE.
  - On reaching TIMEOUT: state -> IDLE, no push, counter cleared.
  - Timeout and RX_DONE in the same cycle: the byte wins, normal transition applies.
- Latency: the final byte's RX_DONE cycle writes the FIFO; EV_VALID rises on the next clk_en edge (1 cycle).
- FIFO:
  - Show-ahead: EV_CODE/EV_EXT/EV_BREAK are registered copies of the head entry and are stable while EV_VALID.
  - Entry width 10 bits.
  - Full with push and no pop: event dropped, OVERFLOW set, FIFO unchanged.
  - Full with push and pop in the same cycle: both happen, count unchanged, no overflow.
  - Empty with push: EV_VALID next cycle. A pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
- OVERFLOW:
  - Set has priority over OVF_CLR in the same cycle.
  - OVF_CLR without clk_en has no effect.
- Reset mid-sequence: state, counters and FIFO cleared next clk edge; any partial prefix is discarded.
- clk_en low: everything holds, including pop. EV_READY is sampled only when clk_en is high.

Optional Feature:
- Macro: PS2_STATUS_FILTER_EN.
- Defined: in IDLE only, bytes AA (BAT pass), FC (BAT fail), FA (ACK), FE (resend), EE (echo), 00 and FF (overrun) are not pushed. Adds output STATUS_SEEN [2:0]:
  - bit0 is a one-cycle pulse on AA.
  - bit1 is sticky on FC/00/FF.
  - bit2 is a one-cycle pulse on FA/FE/EE.
  - bit1 clears with OVF_CLR.
- Undefined: these bytes are ordinary codes and are pushed as events; STATUS_SEEN is absent.

Test Plan:
- Bytes 1C, F0 1C with EV_READY=1 -> events {0,0,1C} then {0,1,1C}; EV_VALID rises 1 clk_en cycle after each final RX_DONE.
- Bytes E0 75, E0 F0 75 -> events {1,0,75} then {1,1,75}; no event is produced for any prefix byte.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,77}; FIFO count 1.
- EV_READY=0, 9 make codes 01..09, DEPTH=8 -> codes 01..08 retained, OVERFLOW=1. Then drain -> 01..08 in order; pulse OVF_CLR -> OVERFLOW=0.
- E0, then no byte for 1023 clk_en cycles, then 1C -> single event {0,0,1C}. A repeat with the byte arriving at cycle 1022 -> {1,0,1C}.
- nRESET low for one clk_en cycle after F0 with 3 events queued -> EV_VALID=0; next byte 2A yields {0,0,2A}. With PS2_STATUS_FILTER_EN defined, AA yields no event and a STATUS_SEEN[0] pulse.
